// File: rtl/i3c_ibi_sched.sv
// i3c_ibi_sched: arbitrates per-source In-Band Interrupt requests onto a single
// I3C target wrapper. Handles NACK retries with a fixed backoff, cancels and
// round-robin or fixed-priority selection.
module i3c_ibi_sched #(
    parameter int          NUM_SRC   = 4,
    parameter int          RETRY_MAX = 3,
    parameter logic [15:0] BACKOFF   = 16'd1000,
    parameter bit          RR_ENA    = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 en,
    input  logic [NUM_SRC-1:0]   src_evt,
    input  logic [NUM_SRC-1:0]   src_cancel,
    input  logic [8*NUM_SRC-1:0] src_byte,
    output logic [NUM_SRC-1:0]   src_pend,
    output logic [NUM_SRC-1:0]   src_done,
    output logic [NUM_SRC-1:0]   src_fail,
    output logic                 ibi_req,
    output logic [7:0]           ibi_byte,
    input  logic                 ibi_done,
    input  logic                 ibi_nacked,
    output logic                 busy,
    output logic [2:0]           act_idx
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_BACKOFF = 2'd2
    } state_t;

    state_t               state_q,    state_d;
    logic [NUM_SRC-1:0]   pend_q,     pend_d;
    logic [NUM_SRC-1:0]   src_done_q, src_done_d;
    logic [NUM_SRC-1:0]   src_fail_q, src_fail_d;
    logic [3:0]           retry_q,    retry_d;
    logic [15:0]          backoff_q,  backoff_d;
    logic [2:0]           act_idx_q,  act_idx_d;
    logic [2:0]           last_q,     last_d;
    logic [7:0]           ibi_byte_q, ibi_byte_d;

    logic                 gnt_vld;
    logic [2:0]           gnt_idx;
    int                   cand;
    logic [NUM_SRC-1:0]   clr_mask;
    logic [NUM_SRC-1:0]   cancel_eff;

    // Arbiter: first pending source, searching from just after the last grant
    // (round-robin) or from index 0 (fixed priority).
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = RR_ENA ? (int'(last_q) + 1 + k) : k;
            if (cand >= NUM_SRC) cand = cand - NUM_SRC;
            if (!gnt_vld && pend_q[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = 3'(cand);
            end
        end
    end

    // Next-state, counters, pulses and pending-flag update.
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        backoff_d  = backoff_q;
        act_idx_d  = act_idx_q;
        last_d     = last_q;
        ibi_byte_d = ibi_byte_q;
        src_done_d = '0;
        src_fail_d = '0;
        clr_mask   = '0;

        // A cancel for the source currently on the bus is dropped.
        cancel_eff = src_cancel;
        if (state_q == S_REQ) cancel_eff[act_idx_q] = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (en && gnt_vld) begin
                    state_d    = S_REQ;
                    act_idx_d  = gnt_idx;
                    last_d     = gnt_idx;
                    ibi_byte_d = src_byte[8*gnt_idx +: 8];
                    retry_d    = '0;
                end
            end
            S_REQ: begin
                if (ibi_done) begin
                    src_done_d[act_idx_q] = 1'b1;
                    clr_mask[act_idx_q]   = 1'b1;
                    state_d               = S_IDLE;
                end else if (ibi_nacked) begin
                    if (retry_q < 4'(RETRY_MAX)) begin
                        retry_d   = retry_q + 4'd1;
                        backoff_d = BACKOFF - 16'd1;
                        state_d   = S_BACKOFF;
                    end else begin
                        src_fail_d[act_idx_q] = 1'b1;
                        clr_mask[act_idx_q]   = 1'b1;
                        state_d               = S_IDLE;
                    end
                end
            end
            S_BACKOFF: begin
                if (!pend_q[act_idx_q]) begin
                    state_d = S_IDLE;
                end else if (backoff_q == 16'd0) begin
                    state_d = S_REQ;
                end else begin
                    backoff_d = backoff_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new event always wins over a coincident clear.
        pend_d = (pend_q & ~(clr_mask | cancel_eff)) | src_evt;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!RSTn) begin
            state_q    <= S_IDLE;
            pend_q     <= '0;
            src_done_q <= '0;
            src_fail_q <= '0;
            retry_q    <= '0;
            backoff_q  <= '0;
            act_idx_q  <= '0;
            last_q     <= 3'(NUM_SRC - 1);
            ibi_byte_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            src_done_q <= src_done_d;
            src_fail_q <= src_fail_d;
            retry_q    <= retry_d;
            backoff_q  <= backoff_d;
            act_idx_q  <= act_idx_d;
            last_q     <= last_d;
            ibi_byte_q <= ibi_byte_d;
        end
    end

    assign ibi_req  = (state_q == S_REQ);
    assign busy     = (state_q != S_IDLE);
    assign src_pend = pend_q;
    assign src_done = src_done_q;
    assign src_fail = src_fail_q;
    assign ibi_byte = ibi_byte_q;
    assign act_idx  = act_idx_q;

endmodule

// File: tb/tb_i3c_ibi_sched.sv
// Self-checking bench for i3c_ibi_sched: table-driven vectors, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_i3c_ibi_sched;

    localparam int          NS    = 4;
    localparam int          RMAX  = 3;
    localparam logic [15:0] BOFF  = 16'd10;

    logic CLK = 1'b0;
    logic RSTn;
    always #5 CLK = ~CLK;

    // Instance A: round-robin, RETRY_MAX=3, BACKOFF=10
    logic          a_en, a_done, a_nack;
    logic [NS-1:0] a_evt, a_cancel, a_pend, a_sdone, a_sfail;
    logic [31:0]   a_byte;
    logic          a_req, a_busy;
    logic [7:0]    a_ibyte;
    logic [2:0]    a_act;

    // Instance B: fixed priority
    logic          b_en, b_done, b_nack;
    logic [NS-1:0] b_evt, b_cancel, b_pend, b_sdone, b_sfail;
    logic [31:0]   b_byte;
    logic          b_req, b_busy;
    logic [7:0]    b_ibyte;
    logic [2:0]    b_act;

    i3c_ibi_sched #(.NUM_SRC(NS), .RETRY_MAX(RMAX), .BACKOFF(BOFF), .RR_ENA(1'b1)) dut_a (
        .CLK(CLK), .RSTn(RSTn), .en(a_en), .src_evt(a_evt), .src_cancel(a_cancel),
        .src_byte(a_byte), .src_pend(a_pend), .src_done(a_sdone), .src_fail(a_sfail),
        .ibi_req(a_req), .ibi_byte(a_ibyte), .ibi_done(a_done), .ibi_nacked(a_nack),
        .busy(a_busy), .act_idx(a_act)
    );

    i3c_ibi_sched #(.NUM_SRC(NS), .RETRY_MAX(1), .BACKOFF(16'd3), .RR_ENA(1'b0)) dut_b (
        .CLK(CLK), .RSTn(RSTn), .en(b_en), .src_evt(b_evt), .src_cancel(b_cancel),
        .src_byte(b_byte), .src_pend(b_pend), .src_done(b_sdone), .src_fail(b_sfail),
        .ibi_req(b_req), .ibi_byte(b_ibyte), .ibi_done(b_done), .ibi_nacked(b_nack),
        .busy(b_busy), .act_idx(b_act)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic wait_req(input bit sel_b, input int max_cyc);
        int n;
        n = 0;
        while (((sel_b ? b_req : a_req) !== 1'b1) && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        n_cmp++;
        if ((sel_b ? b_req : a_req) !== 1'b1) begin
            n_err++;
            $display("FAIL wait_req%s: ibi_req still low after %0d cycles, expected high", sel_b ? "_b" : "_a", max_cyc);
        end
    endtask

    task automatic idle_inputs();
        a_en = 1'b1; a_done = 1'b0; a_nack = 1'b0; a_evt = '0; a_cancel = '0;
        b_en = 1'b1; b_done = 1'b0; b_nack = 1'b0; b_evt = '0; b_cancel = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RSTn = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    // Table vectors: inputs driven for one cycle, outputs expected after the edge.
    typedef struct {
        logic [3:0] evt;
        logic       done;
        logic       nack;
        logic [3:0] e_pend;
        logic       e_req;
        logic       e_busy;
        logic [3:0] e_done;
        logic [7:0] e_byte;
        logic [2:0] e_act;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    // Reference model: one grant at a time, tracked as "active source,
    // attempts used, low cycles remaining".
    bit [3:0]   m_pend, m_sdone, m_sfail;
    int         m_act, m_last, m_idx, m_tries, m_wait;
    bit         m_waiting;
    logic [7:0] m_byte;

    task automatic model_reset();
        m_pend = '0; m_sdone = '0; m_sfail = '0;
        m_act = -1; m_last = NS - 1; m_idx = 0; m_tries = 0; m_wait = 0;
        m_waiting = 1'b0; m_byte = 8'h00;
    endtask

    task automatic model_step(input logic [3:0] evt, input logic [3:0] cancel, input logic en_i,
                              input logic done_i, input logic nack_i, input logic [31:0] bytes);
        bit [3:0] clr;
        int g;
        clr = '0;
        m_sdone = '0;
        m_sfail = '0;
        for (int i = 0; i < NS; i++)
            if (cancel[i] && !(m_act == i && !m_waiting)) clr[i] = 1'b1;
        if (m_act < 0) begin
            g = -1;
            for (int k = 0; k < NS; k++)
                if (g < 0 && m_pend[(m_last + 1 + k) % NS]) g = (m_last + 1 + k) % NS;
            if (en_i && g >= 0) begin
                m_act = g; m_last = g; m_idx = g; m_tries = 0; m_waiting = 1'b0;
                m_byte = bytes[8*g +: 8];
            end
        end else if (!m_waiting) begin
            if (done_i) begin
                m_sdone[m_act] = 1'b1; clr[m_act] = 1'b1; m_act = -1;
            end else if (nack_i) begin
                if (m_tries < RMAX) begin
                    m_tries++; m_waiting = 1'b1; m_wait = int'(BOFF);
                end else begin
                    m_sfail[m_act] = 1'b1; clr[m_act] = 1'b1; m_act = -1;
                end
            end
        end else begin
            if (!m_pend[m_act]) m_act = -1;
            else begin
                m_wait--;
                if (m_wait == 0) m_waiting = 1'b0;
            end
        end
        m_pend = (m_pend & ~clr) | evt;
    endtask

    int         gaps[$];
    int         rises, gap, fail_cnt, ng, bad;
    logic [3:0] fail_v;
    int         order [5];

    initial begin
        vecs[0]  = '{4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000, 8'h00, 3'd0};
        vecs[1]  = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 8'hA5, 3'd2};
        vecs[2]  = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 8'hA5, 3'd2};
        vecs[3]  = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 8'hA5, 3'd2};
        vecs[4]  = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 8'hA5, 3'd2};
        vecs[5]  = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 8'hA5, 3'd2};
        vecs[6]  = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 8'hA5, 3'd2};
        vecs[7]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 8'hA5, 3'd2};
        vecs[8]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'hA5, 3'd2};
        vecs[9]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 8'hA5, 3'd2};
        vecs[10] = '{4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0000, 8'h11, 3'd0};
        vecs[11] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 8'h11, 3'd0};
        vecs[12] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h11, 3'd0};

        a_byte = {8'h3C, 8'hA5, 8'h5A, 8'h11};
        b_byte = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        idle_inputs();
        RSTn = 1'b0;

        // Reset state, observed while reset is still held.
        @(negedge CLK);
        @(negedge CLK);
        check("rst_req",   a_req,   1'b0);
        check("rst_busy",  a_busy,  1'b0);
        check("rst_pend",  a_pend,  4'b0000);
        check("rst_done",  a_sdone, 4'b0000);
        check("rst_fail",  a_sfail, 4'b0000);
        check("rst_byte",  a_ibyte, 8'h00);
        check("rst_act",   a_act,   3'd0);
        check("rst_b_req", b_req,   1'b0);
        RSTn = 1'b1;

        // Single ACK, ignored done/nack outside REQ, done+nack collision.
        for (int r = 0; r < NV; r++) begin
            a_evt = vecs[r].evt; a_done = vecs[r].done; a_nack = vecs[r].nack;
            @(negedge CLK);
            check($sformatf("vec%0d_pend", r), a_pend,  vecs[r].e_pend);
            check($sformatf("vec%0d_req",  r), a_req,   vecs[r].e_req);
            check($sformatf("vec%0d_busy", r), a_busy,  vecs[r].e_busy);
            check($sformatf("vec%0d_done", r), a_sdone, vecs[r].e_done);
            check($sformatf("vec%0d_fail", r), a_sfail, 4'b0000);
            check($sformatf("vec%0d_byte", r), a_ibyte, vecs[r].e_byte);
            check($sformatf("vec%0d_act",  r), a_act,   vecs[r].e_act);
        end
        idle_inputs();

        // Event on the same cycle as done for the same source keeps it pending.
        a_evt = 4'b0010;
        @(negedge CLK);
        a_evt = '0;
        wait_req(1'b0, 10);
        a_done = 1'b1; a_evt = 4'b0010;
        @(negedge CLK);
        a_done = 1'b0; a_evt = '0;
        check("evt_done_coll_done", a_sdone, 4'b0010);
        check("evt_done_coll_pend", a_pend,  4'b0010);

        // Retry then fail: four attempts, 10-cycle gaps, one fail pulse.
        do_reset();
        a_evt = 4'b0010;
        @(negedge CLK);
        a_evt = '0;
        rises = 0; gap = 0; fail_cnt = 0; fail_v = '0;
        gaps.delete();
        for (int c = 0; c < 80; c++) begin
            @(negedge CLK);
            a_nack = 1'b0;
            if (a_sfail != 4'b0000) begin
                fail_cnt++;
                fail_v = a_sfail;
            end
            if (a_req) begin
                rises++;
                if (rises > 1) gaps.push_back(gap);
                gap = 0;
                a_nack = 1'b1;
            end else if (rises > 0) begin
                gap++;
            end
        end
        a_nack = 1'b0;
        check("retry_attempts", rises, 4);
        check("retry_gap_count", gaps.size(), 3);
        foreach (gaps[i]) check($sformatf("retry_gap%0d", i), gaps[i], 10);
        check("retry_fail_vec",  fail_v,   4'b0010);
        check("retry_fail_len",  fail_cnt, 1);
        check("retry_pend",      a_pend,   4'b0000);
        check("retry_busy",      a_busy,   1'b0);

        // Round-robin order with a late re-request of source 0.
        do_reset();
        a_evt = 4'b1111;
        @(negedge CLK);
        a_evt = '0;
        ng = 0;
        foreach (order[i]) order[i] = 7;
        for (int c = 0; c < 100 && ng < 5; c++) begin
            @(negedge CLK);
            a_done = 1'b0; a_evt = '0;
            if (a_req) begin
                order[ng] = int'(a_act);
                ng++;
                a_done = 1'b1;
                if (ng == 2) a_evt = 4'b0001;
            end
        end
        @(negedge CLK);
        idle_inputs();
        check("rr_grants", ng, 5);
        check("rr_order0", order[0], 0);
        check("rr_order1", order[1], 1);
        check("rr_order2", order[2], 2);
        check("rr_order3", order[3], 3);
        check("rr_order4", order[4], 0);

        // Cancel during REQ is ignored; cancel during BACKOFF aborts silently.
        do_reset();
        a_evt = 4'b0100;
        @(negedge CLK);
        a_evt = '0;
        wait_req(1'b0, 10);
        a_cancel = 4'b0100;
        @(negedge CLK);
        a_cancel = '0;
        check("cancel_req_pend", a_pend, 4'b0100);
        check("cancel_req_req",  a_req,  1'b1);
        a_done = 1'b1;
        @(negedge CLK);
        a_done = 1'b0;
        check("cancel_req_done", a_sdone, 4'b0100);
        check("cancel_req_pend2", a_pend, 4'b0000);
        a_evt = 4'b1000;
        @(negedge CLK);
        a_evt = '0;
        wait_req(1'b0, 10);
        a_nack = 1'b1;
        @(negedge CLK);
        a_nack = 1'b0;
        check("cancel_bo_busy", a_busy, 1'b1);
        check("cancel_bo_req",  a_req,  1'b0);
        a_cancel = 4'b1000;
        @(negedge CLK);
        a_cancel = '0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (a_req || a_sdone != 0 || a_sfail != 0) bad++;
        end
        check("cancel_bo_quiet", bad, 0);
        check("cancel_bo_pend",  a_pend, 4'b0000);
        check("cancel_bo_busy2", a_busy, 1'b0);

        // Reset asserted in REQ: everything drops next cycle, no pulses.
        a_evt = 4'b0001;
        @(negedge CLK);
        a_evt = '0;
        wait_req(1'b0, 10);
        RSTn = 1'b0; a_done = 1'b1;
        @(negedge CLK);
        check("rst_mid_req",  a_req,   1'b0);
        check("rst_mid_busy", a_busy,  1'b0);
        check("rst_mid_done", a_sdone, 4'b0000);
        check("rst_mid_fail", a_sfail, 4'b0000);
        check("rst_mid_pend", a_pend,  4'b0000);
        RSTn = 1'b1; a_done = 1'b0;

        // Fixed priority: source 3 starves while source 1 keeps re-requesting.
        do_reset();
        b_evt = 4'b1010;
        @(negedge CLK);
        b_evt = '0;
        for (int g = 0; g < 6; g++) begin
            wait_req(1'b1, 10);
            check($sformatf("fixed_act%0d", g), b_act, 3'd1);
            check($sformatf("fixed_byte%0d", g), b_ibyte, 8'hB1);
            b_done = 1'b1;
            b_evt  = (g < 5) ? 4'b0010 : 4'b0000;
            @(negedge CLK);
            b_done = 1'b0; b_evt = '0;
            check($sformatf("fixed_done%0d", g), b_sdone, 4'b0010);
            check($sformatf("fixed_pend%0d", g), b_pend, (g < 5) ? 4'b1010 : 4'b1000);
        end
        wait_req(1'b1, 10);
        check("fixed_last_act", b_act, 3'd3);
        b_done = 1'b1;
        @(negedge CLK);
        b_done = 1'b0;
        check("fixed_last_done", b_sdone, 4'b1000);
        check("fixed_last_pend", b_pend,  4'b0000);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            check("rnd_pend", a_pend,  m_pend);
            check("rnd_req",  a_req,   m_act >= 0 && !m_waiting);
            check("rnd_busy", a_busy,  m_act >= 0);
            check("rnd_done", a_sdone, m_sdone);
            check("rnd_fail", a_sfail, m_sfail);
            check("rnd_byte", a_ibyte, m_byte);
            check("rnd_act",  a_act,   3'(m_idx));
            for (int i = 0; i < NS; i++) begin
                a_evt[i]    = ($urandom_range(0, 7) == 0);
                a_cancel[i] = ($urandom_range(0, 19) == 0);
            end
            a_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) a_byte = $urandom;
            if (m_act >= 0 && !m_waiting) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: begin a_done = 1'b1; a_nack = 1'b0; end
                    3, 4, 5: begin a_done = 1'b0; a_nack = 1'b1; end
                    6:       begin a_done = 1'b1; a_nack = 1'b1; end
                    default: begin a_done = 1'b0; a_nack = 1'b0; end
                endcase
            end else begin
                a_done = ($urandom_range(0, 9) == 0);
                a_nack = ($urandom_range(0, 9) == 0);
            end
            model_step(a_evt, a_cancel, a_en, a_done, a_nack, a_byte);
            @(negedge CLK);
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i3c_ibi_sched.md
I3C_IBI_SCHED -- requirements
Module: i3c_ibi_sched

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of IBI requesters (legal 1..8).
REQ-002 SHALL have parameter RETRY_MAX, default 3, NACK retries allowed after the first attempt (legal 0..15).
REQ-003 SHALL have parameter BACKOFF, default 16'd1000, CLK cycles waited between a NACK and the next attempt (legal 1..65535).
REQ-004 SHALL have parameter RR_ENA, default 1; 1 selects round-robin arbitration, 0 selects fixed priority with the lowest index first.
REQ-005 Ports:
- CLK  input  1  system clock
- RSTn  input  1  reset; synchronous, active-low
- en  input  1  scheduler enable
- src_evt  input  NUM_SRC  per-source event pulse, 1 CLK wide
- src_cancel  input  NUM_SRC  per-source cancel pulse
- src_byte  input  8*NUM_SRC  per-source mandatory IBI byte; slice [8i+7:8i] belongs to source i
- src_pend  output  NUM_SRC  pending flags
- src_done  output  NUM_SRC  per-source pulse: IBI was ACKed
- src_fail  output  NUM_SRC  per-source pulse: retries exhausted
- ibi_req  output  1  drives the wrapper's i_ibi_req
- ibi_byte  output  8  drives the wrapper's i_ibi_byte
- ibi_done  input  1  the wrapper's o_ibi_done pulse
- ibi_nacked  input  1  the wrapper's o_ibi_nacked pulse
- busy  output  1  high whenever state is not IDLE
- act_idx  output  3  index of the granted source

Function
REQ-006 SHALL hold pend[i]; src_evt[i]=1 sets it on the next edge.
REQ-007 SHALL clear pend[i] on src_cancel[i] unless source i is granted and state is REQ. The cancel is ignored in that case.
REQ-008 SHALL use the FSM states IDLE, REQ and BACKOFF.
REQ-009 IDLE: when en=1 and any pend bit is set, SHALL grant a source on the next edge. The grant loads act_idx, latches src_byte[act_idx] into ibi_byte, clears the retry counter and enters REQ.
REQ-010 With RR_ENA=1, the SHALL-rule search for the grant starts at the index after the last granted source and wraps from NUM_SRC-1 to 0. After reset the last granted index is NUM_SRC-1, so the first search starts at 0.
REQ-011 SHALL drive ibi_req=1 only in REQ, combinationally from state. ibi_byte SHALL stay stable from grant until the scheduler leaves REQ or BACKOFF.
REQ-012 REQ with ibi_done=1: SHALL pulse src_done[act_idx] for 1 cycle, clear pend[act_idx] and go to IDLE.
REQ-013 REQ with ibi_nacked=1 and retry<RETRY_MAX: SHALL increment retry, load the backoff counter with BACKOFF-1 and go to BACKOFF.
REQ-014 REQ with ibi_nacked=1 and retry==RETRY_MAX: SHALL pulse src_fail[act_idx], clear pend[act_idx] and go to IDLE.
REQ-015 If ibi_done and ibi_nacked are both high in the same cycle, ibi_done SHALL win.
REQ-016 BACKOFF: the counter SHALL decrement each cycle. The state SHALL go to REQ when the counter is 0, and to IDLE with no pulses if pend[act_idx] was cleared by a cancel.
REQ-017 ibi_done and ibi_nacked arriving outside REQ SHALL be ignored.
REQ-018 If src_evt[i] coincides with clearing pend[i] (done, fail or cancel), the event SHALL win and pend[i] SHALL remain 1.
REQ-019 en=0 SHALL block new grants only. A source already in REQ or BACKOFF SHALL complete normally, and pend bits SHALL keep latching.
REQ-020 The retry counter SHALL be 4 bits and the backoff counter 16 bits; neither SHALL wrap.
REQ-021 src_pend SHALL equal the pend register. busy SHALL be 1 in REQ and BACKOFF.

Reset
REQ-022 On RSTn=0 at a CLK edge: state=IDLE, pend=0, retry=0, backoff=0, act_idx=0, ibi_byte=8'h00, last granted index=NUM_SRC-1.
REQ-023 During that reset, ibi_req, src_done, src_fail and busy SHALL be 0.
REQ-024 Asserting reset during REQ SHALL drop ibi_req on the following cycle with no done or fail pulse.

Verification
REQ-025 A bench SHALL cover these scenarios:
- Single ACK: src_evt=4'b0100, src_byte[23:16]=8'hA5; ibi_done 5 cycles after ibi_req -> ibi_req rises 1 cycle after the event, ibi_byte=8'hA5, src_done=4'b0100 for 1 cycle, pend=0, busy=0.
- Retry then fail: RETRY_MAX=3, BACKOFF=10, every attempt NACKed -> 4 ibi_req assertions, each gap exactly 10 cycles low, then src_fail[i] for 1 cycle and pend[i]=0.
- Round-robin: src_evt=4'b1111 in one cycle, each IBI ACKed -> grants in order 0,1,2,3. A new evt[0] during grant 1 is serviced after 3.
- Fixed priority (RR_ENA=0): pend=4'b1010 with evt[1] re-asserted after each done -> source 3 is never granted while source 1 stays pending.
- Cancel: cancel the active source during REQ -> ignored, done still pulses. Cancel it during BACKOFF -> returns to IDLE, no pulse, ibi_req stays 0.
- Collisions: ibi_done and ibi_nacked together -> src_done only. evt[i] on the same cycle as done[i] -> pend[i] stays 1. RSTn=0 mid-REQ -> all outputs 0 next cycle.
